// File: rtl/array_rf_pkg.sv
// Shared types for the array refresh controller: FSM state encoding and refresh mode constants.
package array_rf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_TRAS = 2'd2,
      ST_TRP  = 2'd3
   } rf_state_t;

   localparam logic RF_MODE_ALL = 1'b0;
   localparam logic RF_MODE_PER = 1'b1;

endpackage

// File: rtl/array_rf_tcnt.sv
// Phase counter shared by TRAS and TRP: counts 0..lim-1, term is high on the final count.
// Single cycle per count; lim must be at least 1, so lim-1 never underflows.
module array_rf_tcnt #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic [CNT_WIDTH-1:0] lim,
   output logic                 term
);

   logic [CNT_WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign term = (cnt == lim - 1'b1);

endmodule

// File: rtl/array_rf_ctrl_mb.sv
// Multi-bank burst refresh controller: LOAD, then N ops of T active + P precharge cycles.
// Start is accepted only in IDLE; pointers persist across requests so the array is swept.
module array_rf_ctrl_mb
   import array_rf_pkg::*;
#(
   parameter int AXI_RADDR_WIDTH = 14,
   parameter int BANK_NUM        = 2,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CNT_WIDTH-1:0]       mc_tras_cfg,
   input  logic [CNT_WIDTH-1:0]       mc_trp_cfg,
   input  logic [7:0]                 mc_rf_burst_cfg,
   input  logic                       mc_rf_mode_cfg,
   input  logic                       rf_start,
   output logic                       rf_done,
   output logic                       rf_busy,
   output logic                       rf_wrap,
   output logic [BANK_NUM-1:0]        array_banksel_n_rf,
   output logic [AXI_RADDR_WIDTH-1:0] array_raddr_rf
);

   localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
   localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANK_NUM - 1);

   rf_state_t                  state, state_nxt;
   logic [CNT_WIDTH-1:0]       tras_sh, trp_sh, lim;
   logic [7:0]                 ops_left;
   logic                       mode_sh;
   logic [AXI_RADDR_WIDTH-1:0] row_ptr;
   logic [BANK_W-1:0]          bank_ptr;
   logic                       phase_end, op_end, last_op, row_step, cnt_clr;

   // Counter restarts on every phase entry; it is held clear outside TRAS/TRP.
   assign lim     = (state == ST_TRP) ? trp_sh : tras_sh;
   assign cnt_clr = phase_end || !((state == ST_TRAS) || (state == ST_TRP));

   array_rf_tcnt #(.CNT_WIDTH(CNT_WIDTH)) u_tcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .lim   (lim),
      .term  (phase_end)
   );

   assign op_end   = (state == ST_TRP) && phase_end;
   assign last_op  = (ops_left == 8'd1);
   assign row_step = (mode_sh == RF_MODE_ALL) || (bank_ptr == BANK_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (rf_start)  state_nxt = ST_LOAD;
         ST_LOAD:                state_nxt = ST_TRAS;
         ST_TRAS: if (phase_end) state_nxt = ST_TRP;
         ST_TRP:  if (phase_end) state_nxt = last_op ? ST_IDLE : ST_TRAS;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tras_sh  <= CNT_WIDTH'(1);
         trp_sh   <= CNT_WIDTH'(1);
         ops_left <= 8'd1;
         mode_sh  <= RF_MODE_ALL;
         row_ptr  <= '0;
         bank_ptr <= '0;
      end else begin
         state <= state_nxt;
         // Zero configs are mapped to 1 here so the terminal compare never sees 0.
         if ((state == ST_IDLE) && rf_start) begin
            tras_sh  <= (mc_tras_cfg == '0) ? CNT_WIDTH'(1) : mc_tras_cfg;
            trp_sh   <= (mc_trp_cfg == '0) ? CNT_WIDTH'(1) : mc_trp_cfg;
            ops_left <= (mc_rf_burst_cfg == 8'd0) ? 8'd1 : mc_rf_burst_cfg;
            mode_sh  <= mc_rf_mode_cfg;
         end
         if (op_end) begin
            ops_left <= ops_left - 8'd1;
            if (mode_sh == RF_MODE_PER) begin
               bank_ptr <= (bank_ptr == BANK_LAST) ? '0 : bank_ptr + 1'b1;
            end
            if (row_step) begin
               row_ptr <= row_ptr + 1'b1;
            end
         end
      end
   end

   assign rf_busy        = (state != ST_IDLE);
   assign rf_done        = op_end && last_op;
   assign rf_wrap        = op_end && row_step && (row_ptr == '1);
   assign array_raddr_rf = row_ptr;

   always_comb begin
      array_banksel_n_rf = '1;
      for (int b = 0; b < BANK_NUM; b++) begin
         if ((state == ST_TRAS) &&
             ((mode_sh == RF_MODE_ALL) || (bank_ptr == BANK_W'(b)))) begin
            array_banksel_n_rf[b] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_array_rf_ctrl_mb.sv
// Bench for array_rf_ctrl_mb: directed scenarios plus random bursts against a cycle-position model.
module tb_array_rf_ctrl_mb;

   localparam int W  = 4;
   localparam int NB = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] mc_tras_cfg, mc_trp_cfg;
   logic [7:0]    mc_rf_burst_cfg;
   logic          mc_rf_mode_cfg;
   logic          rf_start;
   logic          rf_done, rf_busy, rf_wrap;
   logic [NB-1:0] array_banksel_n_rf;
   logic [W-1:0]  array_raddr_rf;

   int n_tests = 0;
   int n_fail  = 0;
   int row_m   = 0;
   int bank_m  = 0;

   always #5 clk = ~clk;

   array_rf_ctrl_mb #(.AXI_RADDR_WIDTH(W), .BANK_NUM(NB), .CNT_WIDTH(CW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .mc_tras_cfg        (mc_tras_cfg),
      .mc_trp_cfg         (mc_trp_cfg),
      .mc_rf_burst_cfg    (mc_rf_burst_cfg),
      .mc_rf_mode_cfg     (mc_rf_mode_cfg),
      .rf_start           (rf_start),
      .rf_done            (rf_done),
      .rf_busy            (rf_busy),
      .rf_wrap            (rf_wrap),
      .array_banksel_n_rf (array_banksel_n_rf),
      .array_raddr_rf     (array_raddr_rf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " banksel"}, 32'(array_banksel_n_rf), 32'hF);
      chk({tag, " addr"},    32'(array_raddr_rf), 32'(row_m));
      chk({tag, " busy"},    32'(rf_busy), 0);
      chk({tag, " done"},    32'(rf_done), 0);
      chk({tag, " wrap"},    32'(rf_wrap), 0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      row_m  = 0;
      bank_m = 0;
      chk_idle("reset_low");
      rst_n = 1'b1;
      step();
      chk_idle("reset_rel");
   endtask

   // noise: 0 quiet, 1 random start/config churn, 2 starts on cycles 3 and 6 with tras=9
   task automatic do_req(input int t, input int p, input int n, input int mode, input int noise);
      int te, pe, ne, tot, idx, k, r;
      logic [3:0] one, bs_e;
      logic done_e, wrap_e, busy_e, opend;
      string tg;
      te  = (t == 0) ? 1 : t;
      pe  = (p == 0) ? 1 : p;
      ne  = (n == 0) ? 1 : n;
      tot = ne * (te + pe);
      one = 4'b0001;
      mc_tras_cfg     = CW'(t);
      mc_trp_cfg      = CW'(p);
      mc_rf_burst_cfg = 8'(n);
      mc_rf_mode_cfg  = (mode != 0);
      rf_start        = 1'b1;
      step();
      rf_start = 1'b0;
      for (int c = 1; c <= tot + 2; c++) begin
         bs_e   = 4'hF;
         done_e = 1'b0;
         wrap_e = 1'b0;
         opend  = 1'b0;
         busy_e = (c <= tot + 1);
         if (c >= 2 && c <= tot + 1) begin
            idx = c - 2;
            k   = idx / (te + pe);
            r   = idx % (te + pe);
            if (r < te) bs_e = (mode != 0) ? ~(one << bank_m) : 4'h0;
            if (r == te + pe - 1) begin
               opend  = 1'b1;
               done_e = (k == ne - 1);
               wrap_e = (row_m == (1 << W) - 1) && (mode == 0 || bank_m == NB - 1);
            end
         end
         tg = $sformatf("T%0d P%0d N%0d m%0d c%0d", t, p, n, mode, c);
         chk({tg, " banksel"}, 32'(array_banksel_n_rf), 32'(bs_e));
         chk({tg, " addr"},    32'(array_raddr_rf), 32'(row_m));
         chk({tg, " busy"},    32'(rf_busy), 32'(busy_e));
         chk({tg, " done"},    32'(rf_done), 32'(done_e));
         chk({tg, " wrap"},    32'(rf_wrap), 32'(wrap_e));
         if (opend) begin
            if (mode != 0) begin
               bank_m = (bank_m + 1) % NB;
               if (bank_m == 0) row_m = (row_m + 1) % (1 << W);
            end else begin
               row_m = (row_m + 1) % (1 << W);
            end
         end
         if (c <= tot + 1) begin
            if (noise == 1) begin
               rf_start        = 1'($urandom_range(1, 0));
               mc_tras_cfg     = CW'($urandom_range(9, 0));
               mc_trp_cfg      = CW'($urandom_range(9, 0));
               mc_rf_burst_cfg = 8'($urandom_range(9, 0));
               mc_rf_mode_cfg  = 1'($urandom_range(1, 0));
            end else if (noise == 2) begin
               rf_start = (c == 3 || c == 6);
               if (c >= 2) mc_tras_cfg = 8'd9;
            end
            step();
         end
      end
      rf_start = 1'b0;
   endtask

   initial begin
      rst_n           = 1'b0;
      rf_start        = 1'b0;
      mc_tras_cfg     = '0;
      mc_trp_cfg      = '0;
      mc_rf_burst_cfg = '0;
      mc_rf_mode_cfg  = 1'b0;
      step();
      apply_reset();

      do_req(3, 2, 1, 0, 0);
      do_req(3, 2, 1, 0, 2);

      // Reset asserted mid-TRAS abandons the request without a done pulse.
      mc_tras_cfg     = 8'd3;
      mc_trp_cfg      = 8'd2;
      mc_rf_burst_cfg = 8'd1;
      mc_rf_mode_cfg  = 1'b0;
      rf_start        = 1'b1;
      step();
      rf_start = 1'b0;
      step();
      step();
      chk("midtras banksel", 32'(array_banksel_n_rf), 32'h0);
      rst_n = 1'b0;
      step();
      rst_n  = 1'b1;
      row_m  = 0;
      bank_m = 0;
      for (int i = 0; i < 8; i++) chk_idle($sformatf("post_rst c%0d", i));

      do_req(1, 1, 6, 1, 0);
      chk("perbank end addr", 32'(array_raddr_rf), 32'd1);
      do_req(0, 0, 0, 0, 0);
      do_req(1, 1, 1, 1, 0);

      apply_reset();
      do_req(2, 1, 16, 0, 0);
      chk("wrap end addr", 32'(array_raddr_rf), 32'd0);

      for (int i = 0; i < 40; i++) begin
         do_req(int'($urandom_range(4, 0)), int'($urandom_range(3, 0)),
                (i % 8 == 7) ? int'($urandom_range(20, 8)) : int'($urandom_range(6, 0)),
                int'($urandom_range(1, 0)), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
